// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding-select generation for the five-stage MIPS core.
// Tracks the register writers in flight in E, M and W as {wa, tnew} records and
// compares them against the source operands of the instructions in D, E and M.
// Optional feature macro: HAZARD_FWD_W_TO_D_EN (W becomes a D-operand source, code 3).
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    output logic       stall,
    output logic [2:0] fwd_rs_d,
    output logic [2:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic [1:0] fwd_rt_m
);

    logic [4:0] e_wa, m_wa, w_wa;
    logic [1:0] e_tnew, m_tnew, w_tnew;
    logic [4:0] e_rs, e_rt, m_rt;

    // Countdown one step per stage, never below zero.
    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // A record matches a register only for non-zero registers.
    function automatic logic hit(input logic [4:0] wa, input logic [4:0] r);
        return (r != 5'd0) && (wa == r);
    endfunction

    // Operand hazard: a matching producer whose result is still further away than the use.
    function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse,
                                      input logic [4:0] ewa, input logic [1:0] etn,
                                      input logic [4:0] mwa, input logic [1:0] mtn);
        return (hit(ewa, r) && (tuse < etn)) || (hit(mwa, r) && (tuse < mtn));
    endfunction

    // D-operand select: youngest matching record wins; a not-yet-ready match blocks older ones.
    function automatic logic [2:0] d_sel(input logic [4:0] r,
                                         input logic [4:0] ewa, input logic [1:0] etn,
                                         input logic [4:0] mwa, input logic [1:0] mtn,
                                         input logic [4:0] wwa, input logic [1:0] wtn);
        logic [2:0] sel;
        sel = 3'd0;
        if (hit(ewa, r)) begin
            sel = (etn == 2'd0) ? 3'd1 : 3'd0;
        end else if (hit(mwa, r)) begin
            sel = (mtn == 2'd0) ? 3'd2 : 3'd0;
        end else begin
`ifdef HAZARD_FWD_W_TO_D_EN
            sel = (hit(wwa, r) && (wtn == 2'd0)) ? 3'd3 : 3'd0;
`else
            // Register file write-through covers the W producer.
            sel = ((wwa == 5'd0) && (wtn == 2'd0)) ? 3'd0 : 3'd0;
`endif
        end
        return sel;
    endfunction

    // E-operand select: M when its result is ready, otherwise W.
    function automatic logic [1:0] e_sel(input logic [4:0] r,
                                         input logic [4:0] mwa, input logic [1:0] mtn,
                                         input logic [4:0] wwa, input logic [1:0] wtn);
        if (hit(mwa, r) && (mtn == 2'd0))
            return 2'd1;
        else if (hit(wwa, r) && (wtn == 2'd0))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    // Combinational hazard detection and forwarding selects.
    always_comb begin
        stall    = op_stall(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew) ||
                   op_stall(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
        fwd_rs_d = d_sel(d_rs, e_wa, e_tnew, m_wa, m_tnew, w_wa, w_tnew);
        fwd_rt_d = d_sel(d_rt, e_wa, e_tnew, m_wa, m_tnew, w_wa, w_tnew);
        fwd_rs_e = e_sel(e_rs, m_wa, m_tnew, w_wa, w_tnew);
        fwd_rt_e = e_sel(e_rt, m_wa, m_tnew, w_wa, w_tnew);
        fwd_rt_m = (hit(w_wa, m_rt) && (w_tnew == 2'd0)) ? 2'd1 : 2'd0;
    end

    // Advance the writer records; a stall turns the E slot into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_wa   <= 5'd0;
            e_tnew <= 2'd0;
            m_wa   <= 5'd0;
            m_tnew <= 2'd0;
            w_wa   <= 5'd0;
            w_tnew <= 2'd0;
            e_rs   <= 5'd0;
            e_rt   <= 5'd0;
            m_rt   <= 5'd0;
        end else begin
            m_wa   <= e_wa;
            m_tnew <= sat_dec(e_tnew);
            w_wa   <= m_wa;
            w_tnew <= sat_dec(m_tnew);
            m_rt   <= e_rt;
            if (stall) begin
                e_wa   <= 5'd0;
                e_tnew <= 2'd0;
                e_rs   <= 5'd0;
                e_rt   <= 5'd0;
            end else begin
                e_wa   <= d_wa;
                e_tnew <= d_tnew;
                e_rs   <= d_rs;
                e_rt   <= d_rt;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with a scoreboard queue.
// Stimulus pushes the expected output word for a cycle; a monitor pops and compares.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] d_rs = 5'd0, d_rt = 5'd0, d_wa = 5'd0;
    logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = 2'd0;
    logic       stall;
    logic [2:0] fwd_rs_d, fwd_rt_d;
    logic [1:0] fwd_rs_e, fwd_rt_e, fwd_rt_m;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wa(d_wa), .d_tnew(d_tnew),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
    );

    always #5 clk = ~clk;

    // D-stage code expected when only W holds the producer.
`ifdef HAZARD_FWD_W_TO_D_EN
    localparam int WD = 3;
`else
    localparam int WD = 0;
`endif

    typedef struct {
        int          cyc;
        int          tag;
        logic [12:0] exp;
    } exp_t;

    exp_t sbq[$];
    exp_t ent;
    int   cyc = 0;
    int   tag = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Packs {stall, rs_d, rt_d, rs_e, rt_e, rt_m}.
    function automatic logic [12:0] ex(input int s, input int rsd, input int rtd,
                                       input int rse, input int rte, input int rtm);
        return {1'(s), 3'(rsd), 3'(rtd), 2'(rse), 2'(rte), 2'(rtm)};
    endfunction

    task automatic step(input logic rst, input int rs, input int trs, input int rt,
                        input int trt, input int wa, input int tn,
                        input bit chk, input logic [12:0] e);
        reset     = rst;
        d_rs      = 5'(rs);
        d_tuse_rs = 2'(trs);
        d_rt      = 5'(rt);
        d_tuse_rt = 2'(trt);
        d_wa      = 5'(wa);
        d_tnew    = 2'(tn);
        if (chk) begin
            ent.cyc = cyc;
            ent.tag = tag;
            ent.exp = e;
            sbq.push_back(ent);
        end
        tag++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit chk, input logic [12:0] e);
        step(1'b0, 0, 3, 0, 3, 0, 0, chk, e);
    endtask

    task automatic do_reset();
        step(1'b1, 0, 3, 0, 3, 0, 0, 1'b0, 13'd0);
    endtask

    // Monitor: compare the DUT outputs against the queued word for this cycle.
    initial begin
        logic [12:0] got;
        while (!done) begin
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                got = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
                n_cmp++;
                if (got !== sbq[0].exp) begin
                    n_bad++;
                    $display("FAIL vec%0d: got %h required %h (stall,rs_d,rt_d,rs_e,rt_e,rt_m)",
                             sbq[0].tag, got, sbq[0].exp);
                end
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        // Cycle after reset: consumer of $8 with empty records.
        step(0, 8, 0, 8, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0));

        // Load-use: one stall cycle, then W forwarding into E.
        do_reset();
        step(0, 0, 3, 0, 3, 8, 2, 1, ex(0, 0, 0, 0, 0, 0));
        step(0, 8, 1, 0, 3, 10, 1, 1, ex(1, 0, 0, 0, 0, 0));
        step(0, 8, 1, 0, 3, 10, 1, 1, ex(0, 0, 0, 0, 0, 0));
        idle(1, ex(0, 0, 0, 2, 0, 0));

        // Reset during the load-use stall discards it.
        do_reset();
        step(0, 0, 3, 0, 3, 8, 2, 0, 13'd0);
        step(1, 8, 1, 0, 3, 10, 1, 1, ex(1, 0, 0, 0, 0, 0));
        step(0, 8, 1, 0, 3, 10, 1, 1, ex(0, 0, 0, 0, 0, 0));

        // Branch after ALU op: stall, then M forwarding into D.
        do_reset();
        step(0, 0, 3, 0, 3, 9, 1, 0, 13'd0);
        step(0, 9, 0, 0, 3, 0, 0, 1, ex(1, 0, 0, 0, 0, 0));
        step(0, 9, 0, 0, 3, 0, 0, 1, ex(0, 2, 0, 0, 0, 0));

        // Back-to-back ALU: no stall, M forwarding into E.
        do_reset();
        step(0, 0, 3, 0, 3, 5, 1, 0, 13'd0);
        step(0, 0, 3, 5, 1, 6, 1, 1, ex(0, 0, 0, 0, 0, 0));
        idle(1, ex(0, 0, 0, 0, 1, 0));

        // One independent instruction between: M into D, then W into E.
        do_reset();
        step(0, 0, 3, 0, 3, 5, 1, 0, 13'd0);
        idle(0, 13'd0);
        step(0, 0, 3, 5, 1, 0, 0, 1, ex(0, 0, 2, 0, 0, 0));
        idle(1, ex(0, 0, 0, 0, 2, 0));

        // Three deep: producer in W only, rs == rt.
        do_reset();
        step(0, 0, 3, 0, 3, 5, 1, 0, 13'd0);
        idle(0, 13'd0);
        idle(0, 13'd0);
        step(0, 5, 0, 5, 0, 0, 0, 1, ex(0, WD, WD, 0, 0, 0));

        // E forwarding into D when tnew is already 0.
        do_reset();
        step(0, 0, 3, 0, 3, 7, 0, 0, 13'd0);
        step(0, 7, 0, 0, 3, 0, 0, 1, ex(0, 1, 0, 0, 0, 0));

        // Younger not-ready match blocks an older ready one.
        do_reset();
        step(0, 0, 3, 0, 3, 3, 1, 0, 13'd0);
        step(0, 0, 3, 0, 3, 3, 2, 0, 13'd0);
        step(0, 3, 2, 0, 3, 0, 0, 1, ex(0, 0, 0, 0, 0, 0));

        // $0 writer with tnew 0 never forwards or stalls.
        do_reset();
        step(0, 0, 3, 0, 3, 0, 0, 0, 13'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0));

        // Store data: lw then sw, forwarded when the sw reaches M.
        do_reset();
        step(0, 0, 3, 0, 3, 4, 2, 0, 13'd0);
        step(0, 29, 1, 4, 2, 0, 0, 1, ex(0, 0, 0, 0, 0, 0));
        idle(1, ex(0, 0, 0, 0, 0, 0));
        idle(1, ex(0, 0, 0, 0, 0, 1));

        // Load in M stalls a tuse-0 consumer; tuse 3 never stalls.
        do_reset();
        step(0, 0, 3, 0, 3, 8, 2, 0, 13'd0);
        step(0, 8, 3, 0, 3, 0, 0, 1, ex(0, 0, 0, 0, 0, 0));
        step(0, 8, 0, 0, 3, 0, 0, 1, ex(1, 0, 0, 0, 0, 0));
        step(0, 8, 0, 0, 3, 0, 0, 1, ex(0, WD, 0, 0, 0, 0));

        idle(0, 13'd0);
        repeat (2) @(posedge clk);
        done = 1'b1;
        @(negedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d entries left required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
